// File: rtl/pri_decoder_seq.sv
// pri_decoder_seq: sequential 3-to-8 index decoder with a timed one-hot strobe.
// It accepts a 3-bit line index over valid/ready, drives the one-hot line on y
// for PULSE_LEN cycles and then holds off new requests for GAP_LEN cycles.
//
// Ports:
//   clk       clock, rising edge
//   rst_n     synchronous active-low reset
//   in_valid  index request valid
//   in_ready  combinational accept, high only in IDLE
//   in_idx    3-bit line index
//   y         registered one-hot strobe, zero when not driving
//   busy      registered, high while not IDLE
//   done      one-cycle pulse on normal strobe completion
//   err       one-cycle pulse on ack timeout (always 0 without PRIDEC_ACK_EN)
//   ack       per-line acknowledge (PRIDEC_ACK_EN only)
//
// Build option: define PRIDEC_ACK_EN to end the strobe on ack[idx] with a
// TIMEOUT-cycle limit instead of the fixed PULSE_LEN width.
module pri_decoder_seq #(
  parameter int unsigned PULSE_LEN = 4,
  parameter int unsigned GAP_LEN   = 1,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_idx,
  output logic [7:0] y,
  output logic       busy,
  output logic       done,
  output logic       err
`ifdef PRIDEC_ACK_EN
  ,
  input  logic [7:0] ack
`endif
);

  localparam int unsigned LINES = 8;
  localparam int unsigned CNT_W = 8;

`ifdef PRIDEC_ACK_EN
  localparam bit ACK_MODE = 1'b1;
`else
  localparam bit ACK_MODE = 1'b0;
`endif

  // DRIVE length comes from TIMEOUT in ack mode, PULSE_LEN otherwise; 0 acts as 1.
  localparam int unsigned DRIVE_LEN = ACK_MODE ? TIMEOUT : PULSE_LEN;
  localparam logic [CNT_W-1:0] DRIVE_LD = (DRIVE_LEN == 0) ? '0 : CNT_W'(DRIVE_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = (GAP_LEN == 0) ? '0 : CNT_W'(GAP_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [LINES-1:0] y_q, y_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             drive_end;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    y_d       = '0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    drive_end = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // in_ready is high throughout IDLE, so in_valid alone accepts.
        if (in_valid) begin
          idx_d   = in_idx;
          cnt_d   = DRIVE_LD;
          y_d     = LINES'(1) << in_idx;
          state_d = ST_DRIVE;
        end
      end

      ST_DRIVE: begin
        y_d   = LINES'(1) << idx_q;
        cnt_d = cnt_q - CNT_W'(1);
`ifdef PRIDEC_ACK_EN
        // Matching ack wins over a coincident timeout.
        if (ack[idx_q]) begin
          drive_end = 1'b1;
          done_d    = 1'b1;
        end else if (cnt_q == '0) begin
          drive_end = 1'b1;
          err_d     = 1'b1;
        end
`else
        if (cnt_q == '0) begin
          drive_end = 1'b1;
          done_d    = 1'b1;
        end
`endif
        if (drive_end) begin
          y_d = '0;
          if (GAP_LEN == 0) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            state_d = ST_GAP;
            cnt_d   = GAP_LD;
          end
        end
      end

      ST_GAP: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign in_ready = (state_q == ST_IDLE);
  assign y        = y_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_pri_decoder_seq.sv
// Directed bench for pri_decoder_seq: a default-parameter instance (u0) and a
// PULSE_LEN=1/GAP_LEN=0 instance (u1). Expected strobe values are queued when
// a request is driven and popped when the strobe appears on y.
module tb_pri_decoder_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid0, valid1;
  logic [2:0] idx0, idx1;
  logic       rdy0, rdy1;
  logic [7:0] y0, y1;
  logic       busy0, busy1;
  logic       done0, done1;
  logic       err0, err1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t_a, t_b;
  logic [7:0] exp_q[$];

`ifdef PRIDEC_ACK_EN
  localparam logic [7:0] ACK1 = 8'hFF;
  logic [7:0] ack0;
  int         ack_at;
  logic [7:0] ack_mask;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pri_decoder_seq #(.PULSE_LEN(4), .GAP_LEN(1), .TIMEOUT(16)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(valid0), .in_ready(rdy0), .in_idx(idx0),
    .y(y0), .busy(busy0), .done(done0), .err(err0)
`ifdef PRIDEC_ACK_EN
    , .ack(ack0)
`endif
  );

  pri_decoder_seq #(.PULSE_LEN(1), .GAP_LEN(0), .TIMEOUT(16)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(valid1), .in_ready(rdy1), .in_idx(idx1),
    .y(y1), .busy(busy1), .done(done1), .err(err1)
`ifdef PRIDEC_ACK_EN
    , .ack(ACK1)
`endif
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Follow one u0 strobe from its first y cycle through completion and GAP.
  task automatic run_strobe(input int len, input logic d_exp, input logic e_exp,
                            output int t0);
    int g = 0;
    int n = 0;
    logic [7:0] ev;
    while (y0 === 8'h00 && g < 20) begin
      tick();
      g++;
    end
    chk("strobe_seen", 32'(g < 20), 1);
    t0 = cyc;
    ev = exp_q.pop_front();
    chk("y_first", y0, ev);
    chk("busy_drive", busy0, 1);
    chk("ready_drive", rdy0, 0);
    while (y0 === ev && n < 300) begin
      n++;
`ifdef PRIDEC_ACK_EN
      if (n == ack_at) ack0 = ack_mask;
`endif
      tick();
`ifdef PRIDEC_ACK_EN
      if (n == ack_at) ack0 = 8'h00;
`endif
    end
    chk("strobe_len", n, len);
    chk("y_off", y0, 0);
    chk("done_end", done0, d_exp);
    chk("err_end", err0, e_exp);
    chk("ready_gap", rdy0, 0);
    chk("busy_gap", busy0, 1);
    tick();
    chk("done_clear", done0, 0);
    chk("err_clear", err0, 0);
    chk("ready_idle", rdy0, 1);
    chk("busy_idle", busy0, 0);
  endtask

  initial begin
    logic [7:0] ev;
    rst_n  = 1'b0;
    valid0 = 1'b0;
    valid1 = 1'b0;
    idx0   = 3'd0;
    idx1   = 3'd0;
`ifdef PRIDEC_ACK_EN
    ack0     = 8'h00;
    ack_at   = 0;
    ack_mask = 8'h00;
`endif

    // Two reset edges.
    tick();
    tick();
    chk("rst_y", y0, 8'h00);
    chk("rst_ready", rdy0, 1);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_err", err0, 0);
    chk("rst_y1", y1, 8'h00);
    chk("rst_busy1", busy1, 0);
    rst_n = 1'b1;
    tick();

`ifndef PRIDEC_ACK_EN
    // Single request, index 5.
    valid0 = 1'b1; idx0 = 3'd5; exp_q.push_back(8'h20);
    tick();
    valid0 = 1'b0;
    run_strobe(4, 1'b1, 1'b0, t_a);

    // Back-to-back with in_valid held: index 0, then 7.
    valid0 = 1'b1; idx0 = 3'd0; exp_q.push_back(8'h01);
    tick();
    idx0 = 3'd7; exp_q.push_back(8'h80);
    run_strobe(4, 1'b1, 1'b0, t_a);
    tick();
    valid0 = 1'b0;
    run_strobe(4, 1'b1, 1'b0, t_b);
    chk("b2b_period", t_b - t_a, 6);
`else
    // Ack on the 3rd DRIVE cycle ends a 3-cycle strobe with done.
    valid0 = 1'b1; idx0 = 3'd6; exp_q.push_back(8'h40);
    ack_at = 3; ack_mask = 8'h40;
    tick();
    valid0 = 1'b0;
    run_strobe(3, 1'b1, 1'b0, t_a);

    // Ack on a non-selected line only: full timeout, err.
    valid0 = 1'b1; idx0 = 3'd6; exp_q.push_back(8'h40);
    ack_at = 0; ack0 = 8'h02;
    tick();
    valid0 = 1'b0;
    run_strobe(16, 1'b0, 1'b1, t_b);
    ack0 = 8'h00;
    chk("ack_period", t_b - t_a, 5);

    // Ack coinciding with the last timeout edge: done wins.
    valid0 = 1'b1; idx0 = 3'd6; exp_q.push_back(8'h40);
    ack_at = 16; ack_mask = 8'h40;
    tick();
    valid0 = 1'b0;
    run_strobe(16, 1'b1, 1'b0, t_a);
    ack_at = 0;
`endif

    // PULSE_LEN=1, GAP_LEN=0 with index 3 held valid: y toggles every cycle.
    valid1 = 1'b1; idx1 = 3'd3;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back((i % 2 == 0) ? 8'h08 : 8'h00);
      tick();
      ev = exp_q.pop_front();
      chk("tog_y", y1, ev);
      chk("tog_done", done1, 32'(i % 2 == 1));
      chk("tog_ready", rdy1, 32'(i % 2 == 1));
      chk("tog_err", err1, 0);
    end
    valid1 = 1'b0;
    tick();

    // Reset dropped on the 2nd DRIVE cycle discards the strobe without done.
    valid0 = 1'b1; idx0 = 3'd2; exp_q.push_back(8'h04);
    tick();
    valid0 = 1'b0;
    ev = exp_q.pop_front();
    chk("mid_y1", y0, ev);
    tick();
    chk("mid_y2", y0, 8'h04);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_y", y0, 8'h00);
    chk("mid_rst_done", done0, 0);
    chk("mid_rst_busy", busy0, 0);
    chk("mid_rst_ready", rdy0, 1);
    tick();
    chk("mid_no_done", done0, 0);
    chk("mid_idle_y", y0, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
